dvp_frame_tx: RTL and testbench
===============================

# dvp_frame_tx

Parallel-camera (DVP-style) frame transmitter for the camera subsystem. Reads 16-bit pixels from a frame-buffer read port and replays them as a byte stream with VSYNC/HREF framing, high byte first. The framing matches what the camera capture path expects. Used as an on-chip camera emulator for loopback test of the capture path and as a display/link source driven from software-filled frame memory.

## Interface
- `H_ACTIVE`, default 320: pixels per line (≥1); a line spans 2·H_ACTIVE byte cycles.
- `V_ACTIVE`, default 240: lines per frame (≥1).
- `H_BLANK`, default 16: HREF-low cycles between consecutive lines (≥1).
- `VSYNC_LEN`, default 8: cycles VSYNC is held high after START (≥1).
- `V_BP`, default 8: VSYNC-low, HREF-low cycles before the first line (≥1).
- `V_FP`, default 8: VSYNC-low, HREF-low cycles after the last line (≥1).
- `HCLK`  in  1  single clock; all outputs registered on its rising edge.
- `HRESETn`  in  1  **synchronous, active-low reset**.
- `START`  in  1  frame request, sampled only in IDLE.
- `BUSY`  out  1  high from the cycle after START is accepted until frame end.
- `FRAME_DONE`  out  1  one-cycle pulse at frame end.
- `RAM_RADDR`  out  17  pixel read address; linear, 0 .. H_ACTIVE·V_ACTIVE−1.
- `RAM_RDATA`  in  32  read data, one-cycle latency; pixel in [15:0], [31:16] ignored.
- `CAM_DATA`  out  8  byte stream.
- `VSYNC`  out  1  frame sync; high = outside frame.
- `HREF`  out  1  high while CAM_DATA carries valid bytes.

## Operation
- Reset values: `BUSY`=0, `FRAME_DONE`=0, `RAM_RADDR`=0, `CAM_DATA`=0, `VSYNC`=1, `HREF`=0. The state machine returns to IDLE.
- States: IDLE → VS → VBP → LINE ↔ HBL → VFP → IDLE.
- **IDLE**: VSYNC=1. When START=1, go to VS and zero all counters.
- **VS**: VSYNC=1 for VSYNC_LEN cycles, then go to VBP.
- **VBP**: VSYNC=0 for V_BP cycles. On the last VBP cycle, drive RAM_RADDR=0 (prefetch). Then go to LINE.
- **LINE**: HREF=1 for 2·H_ACTIVE cycles. A byte-phase bit toggles every cycle:
  - phase 0 outputs pixel[15:8];
  - phase 1 outputs pixel[7:0] and drives the next address (prefetch).
  - After the last byte: go to HBL if lines remain, otherwise go to VFP.
- **HBL**: HREF=0, CAM_DATA=0 for H_BLANK cycles.
- **VFP**: VSYNC=0, HREF=0 for V_FP cycles. Then VSYNC=1, pulse FRAME_DONE, drop BUSY, return to IDLE.
- Data path: the pixel register loads from RAM_RDATA[15:0] one cycle after its address is driven. CAM_DATA is 0 whenever HREF=0.
- Address rules:
  - RAM_RADDR advances by 1 per pixel and never wraps within a frame.
  - After the final pixel fetch it holds the last value.
  - It is set back to 0 at the next START.
- Counters:
  - Pixel counter: ⌈log2(H_ACTIVE)⌉ bits.
  - Line counter: ⌈log2(V_ACTIVE)⌉ bits.
  - Blank counter: sized to the largest of H_BLANK, VSYNC_LEN, V_BP and V_FP.
  - H_ACTIVE·V_ACTIVE ≤ 131072 is required.
- START while BUSY is ignored; there is no queuing. START held high in IDLE after FRAME_DONE begins a new frame on the next cycle.
- Reset mid-frame: on the next edge, all outputs take their reset values and the frame is abandoned. No FRAME_DONE is issued.

## Timing
- START sampled high at edge N:
  - BUSY=1 at N+1.
  - VSYNC falls at N+1+VSYNC_LEN.
  - First HREF high at N+1+VSYNC_LEN+V_BP.
- Line-start latency from the prefetch address is exactly 1 cycle. Line 0 byte 0 appears the cycle after RAM_RADDR=0 is driven.
- Period of each line plus its gap = 2·H_ACTIVE + H_BLANK. No H_BLANK follows the last line.
- Total frame, from START edge to FRAME_DONE:
  - VSYNC_LEN + V_BP + V_ACTIVE·2·H_ACTIVE + (V_ACTIVE−1)·H_BLANK + V_FP + 1 cycles.
- FRAME_DONE, BUSY falling and VSYNC rising occur in the same cycle.

## Configuration
- `DVP_TX_PATTERN_EN` defined:
  - Adds input `PATTERN` (1 bit), sampled at START and held for the whole frame.
  - When the sampled value is 1, pixel = {line_cnt[7:0], pix_cnt[7:0]}, RAM_RDATA is ignored, and RAM_RADDR still sequences normally.
- Not defined: the `PATTERN` port is absent and pixel data always comes from RAM_RDATA.

## Test plan
Unless stated otherwise, scenarios use H_ACTIVE=4, V_ACTIVE=3, H_BLANK=2, VSYNC_LEN=3, V_BP=2, V_FP=2, with RAM[a] = 0xA000+a.

- **Reset values**: reset → all outputs at their reset values. START pulse → FRAME_DONE exactly 3+2+24+4+2+1 = 36 cycles after the START edge.
- **Byte order and addressing**: CAM_DATA sequence = A0,00,A0,01,…,A0,0B over 24 HREF cycles. HREF low for exactly 2 cycles between lines. RAM_RADDR reaches 11 and holds.
- **START while BUSY**: START held high throughout the frame → no restart mid-frame. A second frame begins the cycle after FRAME_DONE, with RAM_RADDR restarting at 0.
- **Reset mid-frame**: assert HRESETn=0 during line 1, byte 3 → next edge VSYNC=1, HREF=0, BUSY=0, no FRAME_DONE pulse. A new START produces a full, correct frame.
- **Pattern mode** (`DVP_TX_PATTERN_EN` defined, PATTERN=1): line 2, pixel 3 → bytes 0x02 then 0x03.
- **Loopback**: connect to the camera capture block with H_ACTIVE=320, V_ACTIVE=240 → capture memory equals the source frame word-for-word and the capture ready flag asserts.

Source files
------------

// File: rtl/dvp_frame_tx.sv
// dvp_frame_tx: DVP-style camera frame transmitter.
//
// Reads 16-bit pixels from a frame-buffer read port and sends them as a byte
// stream (high byte first) with VSYNC/HREF framing. It serves as an on-chip
// camera emulator and as a frame source fed from software-filled memory.
//
// Optional feature macro: DVP_TX_PATTERN_EN adds a PATTERN input. When PATTERN
// is sampled high at START, pixels are {line[7:0], pixel[7:0]} instead of
// RAM data. RAM_RADDR still steps through the frame in that mode.
//
// Ports:
//   HCLK        in   clock; all outputs are registered on its rising edge
//   HRESETn     in   synchronous active-low reset
//   START       in   frame request, sampled only while idle
//   PATTERN     in   test-pattern select (only with DVP_TX_PATTERN_EN)
//   BUSY        out  high from the cycle after START until frame end
//   FRAME_DONE  out  one-cycle pulse at frame end
//   RAM_RADDR   out  linear pixel read address
//   RAM_RDATA   in   read data for the previous cycle's address, pixel in [15:0]
//   CAM_DATA    out  byte stream, 0 whenever HREF is low
//   VSYNC       out  high outside the frame
//   HREF        out  high while CAM_DATA carries valid bytes

module dvp_frame_tx #(
   parameter int unsigned H_ACTIVE  = 320,
   parameter int unsigned V_ACTIVE  = 240,
   parameter int unsigned H_BLANK   = 16,
   parameter int unsigned VSYNC_LEN = 8,
   parameter int unsigned V_BP      = 8,
   parameter int unsigned V_FP      = 8
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        START,
`ifdef DVP_TX_PATTERN_EN
   input  logic        PATTERN,
`endif
   output logic        BUSY,
   output logic        FRAME_DONE,
   output logic [16:0] RAM_RADDR,
   input  logic [31:0] RAM_RDATA,
   output logic [7:0]  CAM_DATA,
   output logic        VSYNC,
   output logic        HREF
);

   localparam int unsigned PIX_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int unsigned LINE_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int unsigned BLK_MAX01 = (H_BLANK > VSYNC_LEN) ? H_BLANK : VSYNC_LEN;
   localparam int unsigned BLK_MAX23 = (V_BP > V_FP) ? V_BP : V_FP;
   localparam int unsigned BLK_MAX   = (BLK_MAX01 > BLK_MAX23) ? BLK_MAX01 : BLK_MAX23;
   localparam int unsigned BLK_W     = (BLK_MAX > 1) ? $clog2(BLK_MAX) : 1;

   localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(H_ACTIVE - 1);
   localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE - 1);
   localparam logic [BLK_W-1:0]  VS_LAST   = BLK_W'(VSYNC_LEN - 1);
   localparam logic [BLK_W-1:0]  VBP_LAST  = BLK_W'(V_BP - 1);
   localparam logic [BLK_W-1:0]  HBL_LAST  = BLK_W'(H_BLANK - 1);
   localparam logic [BLK_W-1:0]  VFP_LAST  = BLK_W'(V_FP - 1);

   typedef enum logic [2:0] {
      StIdle,
      StVs,
      StVbp,
      StLine,
      StHbl,
      StVfp
   } state_e;

   state_e            state_q, state_d;
   logic [BLK_W-1:0]  blk_q, blk_d;
   logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic              phase_q, phase_d;
   logic [16:0]       addr_q, addr_d;
   logic [15:0]       pix_q, pix_d;
   logic [7:0]        cam_q, cam_d;
   logic              href_q, href_d;
   logic              vsync_q, vsync_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              load;
   logic [15:0]       fetch;
   logic              pattern_q, pattern_d;

   // Upper half of the read word carries no pixel data.
   logic unused_rdata;
   assign unused_rdata = ^RAM_RDATA[31:16];

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q   <= StIdle;
         blk_q     <= '0;
         pix_cnt_q <= '0;
         line_q    <= '0;
         phase_q   <= 1'b0;
         addr_q    <= '0;
         pix_q     <= '0;
         cam_q     <= '0;
         href_q    <= 1'b0;
         vsync_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pattern_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         blk_q     <= blk_d;
         pix_cnt_q <= pix_cnt_d;
         line_q    <= line_d;
         phase_q   <= phase_d;
         addr_q    <= addr_d;
         pix_q     <= pix_d;
         cam_q     <= cam_d;
         href_q    <= href_d;
         vsync_q   <= vsync_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pattern_q <= pattern_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      blk_d     = blk_q;
      pix_cnt_d = pix_cnt_q;
      line_d    = line_q;
      phase_d   = phase_q;
      addr_d    = addr_q;
      pix_d     = pix_q;
      cam_d     = 8'h00;
      href_d    = 1'b0;
      vsync_d   = vsync_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      pattern_d = pattern_q;
      load      = 1'b0;

      unique case (state_q)
         StIdle: begin
            vsync_d = 1'b1;
            busy_d  = 1'b0;
            if (START) begin
               state_d   = StVs;
               busy_d    = 1'b1;
               blk_d     = '0;
               pix_cnt_d = '0;
               line_d    = '0;
               phase_d   = 1'b0;
               addr_d    = '0;
`ifdef DVP_TX_PATTERN_EN
               pattern_d = PATTERN;
`endif
            end
         end
         StVs: begin
            if (blk_q == VS_LAST) begin
               state_d = StVbp;
               vsync_d = 1'b0;
               blk_d   = '0;
            end else begin
               blk_d = blk_q + 1'b1;
            end
         end
         StVbp: begin
            // Address 0 is already on the bus here, so its data can be loaded now.
            addr_d = '0;
            if (blk_q == VBP_LAST) begin
               state_d = StLine;
               href_d  = 1'b1;
               load    = 1'b1;
            end else begin
               blk_d = blk_q + 1'b1;
            end
         end
         StLine: begin
            if (!phase_q) begin
               // Low byte goes out now; prefetch the next pixel unless this is the last.
               href_d  = 1'b1;
               cam_d   = pix_q[7:0];
               phase_d = 1'b1;
               if (!(pix_cnt_q == PIX_LAST && line_q == LINE_LAST)) begin
                  addr_d = addr_q + 17'd1;
               end
            end else if (pix_cnt_q != PIX_LAST) begin
               href_d    = 1'b1;
               phase_d   = 1'b0;
               pix_cnt_d = pix_cnt_q + 1'b1;
               load      = 1'b1;
            end else begin
               phase_d   = 1'b0;
               pix_cnt_d = '0;
               blk_d     = '0;
               if (line_q == LINE_LAST) begin
                  state_d = StVfp;
               end else begin
                  state_d = StHbl;
                  line_d  = line_q + 1'b1;
               end
            end
         end
         StHbl: begin
            if (blk_q == HBL_LAST) begin
               state_d = StLine;
               href_d  = 1'b1;
               load    = 1'b1;
            end else begin
               blk_d = blk_q + 1'b1;
            end
         end
         StVfp: begin
            if (blk_q == VFP_LAST) begin
               state_d = StIdle;
               vsync_d = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               blk_d = blk_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // The counters' next values index the pixel being loaded.
      fetch = RAM_RDATA[15:0];
`ifdef DVP_TX_PATTERN_EN
      if (pattern_q) begin
         fetch = {8'(line_d), 8'(pix_cnt_d)};
      end
`endif
      if (load) begin
         pix_d = fetch;
         cam_d = fetch[15:8];
      end
   end

   assign BUSY       = busy_q;
   assign FRAME_DONE = done_q;
   assign RAM_RADDR  = addr_q;
   assign CAM_DATA   = cam_q;
   assign VSYNC      = vsync_q;
   assign HREF       = href_q;

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Testbench for dvp_frame_tx with a small frame (4x3 pixels).
// Expected outputs come from a per-cycle frame trace built from the framing
// rules: sync, back porch, lines with blanking, front porch, done cycle.

module tb_dvp_frame_tx;

   localparam int unsigned H    = 4;
   localparam int unsigned V    = 3;
   localparam int unsigned HB   = 2;
   localparam int unsigned VL   = 3;
   localparam int unsigned VBP  = 2;
   localparam int unsigned VFP  = 2;
   localparam int unsigned NPIX = H * V;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        START = 1'b0;
`ifdef DVP_TX_PATTERN_EN
   logic        pat_in = 1'b0;
`endif
   logic        BUSY;
   logic        FRAME_DONE;
   logic [16:0] RAM_RADDR;
   logic [31:0] RAM_RDATA;
   logic [7:0]  CAM_DATA;
   logic        VSYNC;
   logic        HREF;

   logic [31:0] mem [16];
   bit          pat_mode = 1'b0;
   int          total = 0;
   int          bad = 0;

   typedef struct packed {
      logic        vs;
      logic        hr;
      logic        bz;
      logic        dn;
      logic [7:0]  cam;
      logic [16:0] addr;
   } obs_t;

   obs_t exp_q[$];

   always #5 HCLK = ~HCLK;

   // Read port: data for the registered address is available the next edge.
   assign RAM_RDATA = (RAM_RADDR < 17'(NPIX)) ? mem[RAM_RADDR[3:0]] : 32'hDEAD_BEEF;

   dvp_frame_tx #(
      .H_ACTIVE  (H),
      .V_ACTIVE  (V),
      .H_BLANK   (HB),
      .VSYNC_LEN (VL),
      .V_BP      (VBP),
      .V_FP      (VFP)
   ) dut (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .START      (START),
`ifdef DVP_TX_PATTERN_EN
      .PATTERN    (pat_in),
`endif
      .BUSY       (BUSY),
      .FRAME_DONE (FRAME_DONE),
      .RAM_RADDR  (RAM_RADDR),
      .RAM_RDATA  (RAM_RDATA),
      .CAM_DATA   (CAM_DATA),
      .VSYNC      (VSYNC),
      .HREF       (HREF)
   );

   function automatic obs_t mk(input logic vs, input logic hr, input logic bz, input logic dn,
                               input logic [7:0] cam, input int addr);
      obs_t o;
      o.vs   = vs;
      o.hr   = hr;
      o.bz   = bz;
      o.dn   = dn;
      o.cam  = cam;
      o.addr = 17'(addr);
      return o;
   endfunction

   function automatic logic [15:0] pix_val(input int l, input int p);
      logic [31:0] w;
      if (pat_mode) return {8'(l), 8'(p)};
      w = mem[l * H + p];
      return w[15:0];
   endfunction

   function automatic obs_t observe();
      return mk(VSYNC, HREF, BUSY, FRAME_DONE, CAM_DATA, int'(RAM_RADDR));
   endfunction

   task automatic build_trace();
      logic [15:0] px;
      int g;
      exp_q.delete();
      for (int i = 0; i < VL; i++) exp_q.push_back(mk(1, 0, 1, 0, 8'h00, 0));
      for (int i = 0; i < VBP; i++) exp_q.push_back(mk(0, 0, 1, 0, 8'h00, 0));
      for (int l = 0; l < V; l++) begin
         for (int p = 0; p < H; p++) begin
            g  = l * H + p;
            px = pix_val(l, p);
            exp_q.push_back(mk(0, 1, 1, 0, px[15:8], g));
            exp_q.push_back(mk(0, 1, 1, 0, px[7:0], (g + 1 < NPIX) ? g + 1 : NPIX - 1));
         end
         if (l < V - 1) begin
            for (int i = 0; i < HB; i++) exp_q.push_back(mk(0, 0, 1, 0, 8'h00, (l + 1) * H));
         end
      end
      for (int i = 0; i < VFP; i++) exp_q.push_back(mk(0, 0, 1, 0, 8'h00, NPIX - 1));
      exp_q.push_back(mk(1, 0, 0, 1, 8'h00, NPIX - 1));
   endtask

   task automatic fill_random();
      for (int a = 0; a < 16; a++) mem[a] = $urandom;
   endtask

   task automatic cmp(input string name, input int cyc, input obs_t got, input obs_t want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d got vs=%b href=%b busy=%b done=%b cam=%h addr=%0d want vs=%b href=%b busy=%b done=%b cam=%h addr=%0d",
                  name, cyc, got.vs, got.hr, got.bz, got.dn, got.cam, got.addr,
                  want.vs, want.hr, want.bz, want.dn, want.cam, want.addr);
      end
   endtask

   // START must have been sampled at the edge before this is called.
   // Checks up to stop_after cycles (0 = whole frame).
   task automatic check_frame(input string name, input bit keep_start, input int stop_after);
      int n;
      build_trace();
      n = (stop_after != 0) ? stop_after : exp_q.size();
      for (int k = 0; k < n; k++) begin
         @(negedge HCLK);
         cmp(name, k + 1, observe(), exp_q[k]);
         if (!keep_start) START = 1'b0;
      end
   endtask

   task automatic start_and_check(input string name);
      START = 1'b1;
      check_frame(name, 1'b0, 0);
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      START   = 1'b1;
      repeat (3) @(negedge HCLK);
      cmp("reset_vals", 0, observe(), mk(1, 0, 0, 0, 8'h00, 0));
      START   = 1'b0;
      HRESETn = 1'b1;
      @(negedge HCLK);
      cmp("idle_after_reset", 0, observe(), mk(1, 0, 0, 0, 8'h00, 0));
      fill_random();
      start_and_check("frame_len");
      // After the done pulse the address holds the last pixel and nothing else moves.
      repeat (3) begin
         @(negedge HCLK);
         cmp("idle_hold", 0, observe(), mk(1, 0, 0, 0, 8'h00, NPIX - 1));
      end
   endtask

   task automatic test_byte_order();
      for (int a = 0; a < 16; a++) mem[a] = {16'($urandom), 16'hA000 + 16'(a)};
      @(negedge HCLK);
      start_and_check("byte_order");
   endtask

   task automatic test_back_to_back();
      fill_random();
      @(negedge HCLK);
      START = 1'b1;
      check_frame("busy_frame1", 1'b1, 0);
      check_frame("busy_frame2", 1'b0, 0);
      @(negedge HCLK);
      cmp("after_frame2", 0, observe(), mk(1, 0, 0, 0, 8'h00, NPIX - 1));
   endtask

   task automatic test_reset_mid(input int abort_cycle);
      fill_random();
      @(negedge HCLK);
      START = 1'b1;
      check_frame("pre_abort", 1'b0, abort_cycle);
      HRESETn = 1'b0;
      @(negedge HCLK);
      cmp("abort_reset", abort_cycle + 1, observe(), mk(1, 0, 0, 0, 8'h00, 0));
      HRESETn = 1'b1;
      repeat (5) begin
         @(negedge HCLK);
         cmp("abort_quiet", 0, observe(), mk(1, 0, 0, 0, 8'h00, 0));
      end
      fill_random();
      start_and_check("after_abort");
   endtask

   task automatic test_random();
      int gap;
      for (int it = 0; it < 4; it++) begin
         fill_random();
         gap = $urandom_range(0, 5);
         for (int i = 0; i < gap; i++) begin
            @(negedge HCLK);
            cmp("rand_gap", i, observe(), mk(1, 0, 0, 0, 8'h00, NPIX - 1));
         end
         start_and_check("rand_frame");
      end
   endtask

`ifdef DVP_TX_PATTERN_EN
   task automatic test_pattern();
      fill_random();
      pat_in   = 1'b1;
      pat_mode = 1'b1;
      @(negedge HCLK);
      start_and_check("pattern");
      pat_in   = 1'b0;
      pat_mode = 1'b0;
      fill_random();
      @(negedge HCLK);
      start_and_check("pattern_off");
   endtask
`endif

   initial begin
      for (int a = 0; a < 16; a++) mem[a] = 32'h0;
      test_reset();
      test_byte_order();
      test_back_to_back();
      // Line 1, byte 3: sync + back porch + line 0 + blank + 4 bytes.
      test_reset_mid(VL + VBP + 2 * H + HB + 4);
      test_reset_mid($urandom_range(2, VL + VBP + V * 2 * H));
      test_random();
`ifdef DVP_TX_PATTERN_EN
      test_pattern();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
